mxv_ctrl: RTL

MXV_CTRL -- requirements
Module: mxv_ctrl

---
 rtl/mxv_ctrl_if.sv | 37 +++
 rtl/mxv_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mxv_ctrl_if.sv
// Handshake and control bundle between the 8x4 matrix-vector controller and its datapath.
interface mxv_ctrl_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       push_vector;
    logic       pop_vector;
    logic [7:0] push_matrix;
    logic [7:0] pop_matrix;
    logic [1:0] dmx_v_sltr;
    logic       mx_reg_sltr;
    logic       mx_a_sltr;
    logic       mx_b_sltr;
    logic       mx_c_sltr;
    logic       mx_d_sltr;
    logic       ena_proc_a;
    logic       ena_proc_b;
    logic       ena_proc_c;
    logic       ena_proc_d;
    logic       push_result;

    modport master (
        output start, in_valid,
        input  in_ready, busy, done, push_vector, pop_vector, push_matrix, pop_matrix,
               dmx_v_sltr, mx_reg_sltr, mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr,
               ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d, push_result
    );

    modport slave (
        input  start, in_valid,
        output in_ready, busy, done, push_vector, pop_vector, push_matrix, pop_matrix,
               dmx_v_sltr, mx_reg_sltr, mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr,
               ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d, push_result
    );
endinterface

// File: rtl/mxv_ctrl.sv
// Controller for an 8x4 matrix times 4-vector job: load, distribute, systolic compute, done.
// Optional feature: MXV_CTRL_PERF_CNT_EN adds a 16-bit saturating busy-cycle counter.
module mxv_ctrl (
    input  logic        clk,
    input  logic        rst,
`ifdef MXV_CTRL_PERF_CNT_EN
    output logic [15:0] perf_cycles,
`endif
    mxv_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_VEC,
        LOAD_MAT,
        DIST_VEC,
        COMPUTE,
        DONE
    } state_t;

    typedef struct packed {
        logic [7:0] pop;
        logic [3:0] ena;
        logic [3:0] sel;
        logic       push;
    } sched_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] cnt;
    logic [5:0] cnt_nxt;
    logic       xfer;

    logic       in_ready_d;
    logic       busy_d;
    logic       done_d;
    logic       push_vector_d;
    logic       pop_vector_d;
    logic [7:0] push_matrix_d;
    logic [1:0] dmx_d;
    sched_t     sched_d;

    // Column c works on row k-c in compute cycle k; its processor fires one cycle after the pop.
    function automatic sched_t compute_sched(input logic [3:0] k);
        sched_t s;
        int     row;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            row = int'(k) - c;
            if (row >= 0 && row < 8)
                s.pop[(row >= 4 ? 3'd4 : 3'd0) + 3'(c)] = 1'b1;
            row = int'(k) - c - 1;
            if (row >= 0 && row < 8) begin
                s.ena[2'(c)] = 1'b1;
                s.sel[2'(c)] = (row >= 4);
            end
        end
        s.push = (k >= 4'd4) && (k <= 4'd11);
        return s;
    endfunction

    assign xfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD_VEC;
                    cnt_nxt   = '0;
                end
            end
            LOAD_VEC: begin
                if (xfer) begin
                    if (cnt == 6'd3) begin
                        state_nxt = LOAD_MAT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            LOAD_MAT: begin
                if (xfer) begin
                    if (cnt == 6'd31) begin
                        state_nxt = DIST_VEC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            DIST_VEC: begin
                if (cnt == 6'd3) begin
                    state_nxt = COMPUTE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            COMPUTE: begin
                if (cnt == 6'd11) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        in_ready_d    = (state_nxt == LOAD_VEC) || (state_nxt == LOAD_MAT);
        busy_d        = (state_nxt != IDLE);
        done_d        = (state_nxt == DONE);
        pop_vector_d  = (state_nxt == DIST_VEC);
        dmx_d         = (state_nxt == DIST_VEC) ? cnt_nxt[1:0] : 2'd0;
        push_vector_d = (state == LOAD_VEC) && xfer;
        push_matrix_d = '0;
        if (state == LOAD_MAT && xfer)
            push_matrix_d[{cnt[4], cnt[1:0]}] = 1'b1;
        sched_d = (state_nxt == COMPUTE) ? compute_sched(cnt_nxt[3:0]) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.push_vector <= 1'b0;
            bus.pop_vector  <= 1'b0;
            bus.push_matrix <= '0;
            bus.pop_matrix  <= '0;
            bus.dmx_v_sltr  <= '0;
            bus.mx_reg_sltr <= 1'b0;
            bus.mx_a_sltr   <= 1'b0;
            bus.mx_b_sltr   <= 1'b0;
            bus.mx_c_sltr   <= 1'b0;
            bus.mx_d_sltr   <= 1'b0;
            bus.ena_proc_a  <= 1'b0;
            bus.ena_proc_b  <= 1'b0;
            bus.ena_proc_c  <= 1'b0;
            bus.ena_proc_d  <= 1'b0;
            bus.push_result <= 1'b0;
        end else begin
            bus.in_ready    <= in_ready_d;
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.push_vector <= push_vector_d;
            bus.pop_vector  <= pop_vector_d;
            bus.push_matrix <= push_matrix_d;
            bus.pop_matrix  <= sched_d.pop;
            bus.dmx_v_sltr  <= dmx_d;
            bus.mx_reg_sltr <= 1'b0;
            bus.mx_a_sltr   <= sched_d.sel[0];
            bus.mx_b_sltr   <= sched_d.sel[1];
            bus.mx_c_sltr   <= sched_d.sel[2];
            bus.mx_d_sltr   <= sched_d.sel[3];
            bus.ena_proc_a  <= sched_d.ena[0];
            bus.ena_proc_b  <= sched_d.ena[1];
            bus.ena_proc_c  <= sched_d.ena[2];
            bus.ena_proc_d  <= sched_d.ena[3];
            bus.push_result <= sched_d.push;
        end
    end

`ifdef MXV_CTRL_PERF_CNT_EN
    // The accepting cycle is counted as the first cycle of the job.
    always_ff @(posedge clk) begin
        if (rst)
            perf_cycles <= '0;
        else if (state == IDLE && bus.start)
            perf_cycles <= 16'd1;
        else if (state != IDLE && perf_cycles != 16'hFFFF)
            perf_cycles <= perf_cycles + 16'd1;
    end
`endif

endmodule
